// File: rtl/conv_fp_pkg.sv
// Shared sign-magnitude fixed-point definitions for the 3x3 convolution datapath.
// Word layout: MSB is the sign, the remaining bits hold the magnitude.
package conv_fp_pkg;

    localparam int DEF_FP_WORD_LENGTH = 11;
    localparam int DEF_FP_FRAC_LENGTH = 0;
    localparam int DEF_MAG_W          = DEF_FP_WORD_LENGTH - 1;
    localparam int DEF_TAPS           = 9;
    localparam int DEF_PIX_W          = 8;

    localparam logic [DEF_MAG_W-1:0] MAG_MAX = '1;

    typedef struct packed {
        logic                 sign;
        logic [DEF_MAG_W-1:0] mag;
    } sm_word_t;

    typedef logic [DEF_PIX_W-1:0] pixel_t;

endpackage

// File: rtl/sm_add_ovf.sv
// Combinational sign-magnitude adder with magnitude-overflow flag.
// CONV_ACCUM_SAT_EN: saturate same-sign overflow instead of wrapping the magnitude.
module sm_add_ovf
    import conv_fp_pkg::*;
#(
    parameter int W = DEF_FP_WORD_LENGTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    localparam int M = W - 1;

    logic         a_sign;
    logic         b_sign;
    logic [M-1:0] a_mag;
    logic [M-1:0] b_mag;
    logic [M:0]   mag_sum;
    logic [M-1:0] res_mag;
    logic         res_sign;

    assign a_sign  = a[W-1];
    assign b_sign  = b[W-1];
    assign a_mag   = a[M-1:0];
    assign b_mag   = b[M-1:0];
    assign mag_sum = {1'b0, a_mag} + {1'b0, b_mag};

    // Any zero result is forced to +0 so negative zero never leaves this block.
    always_comb begin
        ovf      = 1'b0;
        res_mag  = '0;
        res_sign = 1'b0;
        if (a_sign == b_sign) begin
            ovf      = mag_sum[M];
            res_sign = a_sign;
`ifdef CONV_ACCUM_SAT_EN
            res_mag  = mag_sum[M] ? {M{1'b1}} : mag_sum[M-1:0];
`else
            res_mag  = mag_sum[M-1:0];
`endif
        end else if (a_mag > b_mag) begin
            res_mag  = a_mag - b_mag;
            res_sign = a_sign;
        end else if (b_mag > a_mag) begin
            res_mag  = b_mag - a_mag;
            res_sign = b_sign;
        end
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
        sum = {res_sign, res_mag};
    end

endmodule

// File: rtl/conv_win_accum.sv
// Window accumulator: sums TAPS sign-magnitude products per window and emits the
// signed sum plus a clamped pixel. Overflow mode follows CONV_ACCUM_SAT_EN in sm_add_ovf.
module conv_win_accum
    import conv_fp_pkg::*;
#(
    parameter int FP_WORD_LENGTH = DEF_FP_WORD_LENGTH,
    parameter int FP_FRAC_LENGTH = DEF_FP_FRAC_LENGTH,
    parameter int TAPS           = DEF_TAPS,
    parameter int PIX_W          = DEF_PIX_W
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [FP_WORD_LENGTH-1:0] s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [FP_WORD_LENGTH-1:0] m_data,
    output logic [PIX_W-1:0]          m_pixel,
    output logic                      m_ovf
);

    localparam int MAG_W   = FP_WORD_LENGTH - 1;
    localparam int CNT_W   = $clog2(TAPS);
    localparam int CLAMP_W = (MAG_W > PIX_W) ? MAG_W : PIX_W;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    logic [CNT_W-1:0]          tap_cnt;
    logic [FP_WORD_LENGTH-1:0] acc;
    logic                      ovf_acc;
    logic [FP_WORD_LENGTH-1:0] step_sum;
    logic                      step_ovf;
    logic [FP_WORD_LENGTH-1:0] tap0_data;
    logic                      first_tap;
    logic                      last_tap;
    logic                      accept;
    logic [MAG_W-1:0]          final_mag;
    logic [CLAMP_W-1:0]        mag_scaled;
    logic [PIX_W-1:0]          pixel_next;

    assign first_tap = (tap_cnt == '0);
    assign last_tap  = (tap_cnt == LAST_TAP);

    // Only the closing tap must wait for a free output register.
    assign s_ready   = !(m_valid && !m_ready && last_tap);
    assign accept    = s_valid && s_ready;

    assign tap0_data = (s_data[MAG_W-1:0] == '0) ? '0 : s_data;

    sm_add_ovf #(
        .W (FP_WORD_LENGTH)
    ) u_add (
        .a   (acc),
        .b   (s_data),
        .sum (step_sum),
        .ovf (step_ovf)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tap_cnt <= '0;
        end else if (accept) begin
            tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (accept) begin
            if (first_tap) begin
                acc     <= tap0_data;
                ovf_acc <= 1'b0;
            end else begin
                acc     <= step_sum;
                ovf_acc <= ovf_acc | step_ovf;
            end
        end
    end

    // Pixel drops the fractional bits, then clamps to the pixel range.
    assign final_mag  = step_sum[MAG_W-1:0];
    assign mag_scaled = CLAMP_W'(final_mag) >> FP_FRAC_LENGTH;

    always_comb begin
        pixel_next = mag_scaled[PIX_W-1:0];
        if (mag_scaled > CLAMP_W'({PIX_W{1'b1}})) begin
            pixel_next = '1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_pixel <= '0;
            m_ovf   <= 1'b0;
        end else if (accept && last_tap) begin
            m_valid <= 1'b1;
            m_data  <= step_sum;
            m_pixel <= pixel_next;
            m_ovf   <= ovf_acc | step_ovf;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_win_accum.sv
// Scoreboard bench for conv_win_accum: directed windows push expected results,
// a monitor pops them on every output handshake.
`timescale 1ns/1ps
module tb_conv_win_accum;
    import conv_fp_pkg::*;

    localparam int W     = DEF_FP_WORD_LENGTH;
    localparam int MAG_W = DEF_MAG_W;
    localparam int TAPS  = DEF_TAPS;

    typedef struct packed {
        logic [W-1:0] data;
        pixel_t       pixel;
        logic         ovf;
    } result_t;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [W-1:0] m_data;
    pixel_t       m_pixel;
    logic         m_ovf;

    result_t      exp_q[$];
    logic [W-1:0] win [TAPS];
    logic [W-1:0] stream [2*TAPS];
    logic [20:1]  mv_seen;
    int           accepts;
    int           check_count = 0;
    int           error_count = 0;

    conv_win_accum dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_pixel (m_pixel),
        .m_ovf   (m_ovf)
    );

    always #5 aclk = ~aclk;

    function automatic logic [W-1:0] sm(input int v);
        logic [MAG_W-1:0] mag;
        mag = (v < 0) ? MAG_W'(-v) : MAG_W'(v);
        return {(v < 0) ? 1'b1 : 1'b0, mag};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake consumes one expected result.
    always @(negedge aclk) begin
        result_t e;
        if (aresetn && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected result", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_output("m_data", 32'(m_data), 32'(e.data));
                check_output("m_pixel", 32'(m_pixel), 32'(e.pixel));
                check_output("m_ovf", 32'(m_ovf), 32'(e.ovf));
            end
        end
    end

    task automatic send_tap(input logic [W-1:0] d);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge aclk);
        while (!s_ready && waited < 50) begin
            waited++;
            @(negedge aclk);
        end
        if (!s_ready) check_output("tap accept timeout", 32'(s_ready), 32'd1);
        @(posedge aclk);
        #1;
    endtask

    task automatic apply_stimulus(input result_t exp);
        exp_q.push_back(exp);
        for (int i = 0; i < TAPS; i++) send_tap(win[i]);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got time limit expected summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        check_output("reset m_valid", 32'(m_valid), 32'd0);
        check_output("reset m_data", 32'(m_data), 32'd0);
        check_output("reset m_pixel", 32'(m_pixel), 32'd0);
        check_output("reset m_ovf", 32'(m_ovf), 32'd0);
        check_output("reset s_ready", 32'(s_ready), 32'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        idle(2);

        win = '{sm(100), sm(200), sm(100), sm(0), sm(0), sm(0), sm(-10), sm(-20), sm(-10)};
        apply_stimulus('{data: 11'h168, pixel: 8'd255, ovf: 1'b0});
        idle(3);

        win = '{sm(-5), sm(5), sm(0), sm(0), sm(0), sm(0), sm(0), sm(0), 11'h400};
        apply_stimulus('{data: 11'h000, pixel: 8'd0, ovf: 1'b0});
        idle(3);

        for (int i = 0; i < TAPS; i++) win[i] = 11'h3FF;
`ifdef CONV_ACCUM_SAT_EN
        apply_stimulus('{data: 11'h3FF, pixel: 8'd255, ovf: 1'b1});
`else
        apply_stimulus('{data: 11'h3F7, pixel: 8'd255, ovf: 1'b1});
`endif
        idle(3);

        for (int i = 0; i < TAPS; i++) win[i] = sm(-3);
        apply_stimulus('{data: 11'h41B, pixel: 8'd27, ovf: 1'b0});
        idle(2);

        win = '{sm(200), sm(54), sm(0), sm(0), sm(0), sm(0), sm(0), sm(0), sm(0)};
        apply_stimulus('{data: 11'h0FE, pixel: 8'd254, ovf: 1'b0});
        win = '{sm(255), sm(0), sm(0), sm(0), sm(0), sm(0), sm(0), sm(0), sm(0)};
        apply_stimulus('{data: 11'h0FF, pixel: 8'd255, ovf: 1'b0});
        win = '{sm(0), sm(0), sm(0), sm(0), sm(0), sm(0), sm(0), sm(0), sm(256)};
        apply_stimulus('{data: 11'h100, pixel: 8'd255, ovf: 1'b0});
        idle(3);

        // Backpressure: A is held while B streams; B's last tap must stall.
        m_ready = 1'b0;
        for (int i = 0; i < TAPS; i++) win[i] = sm(2);
        apply_stimulus('{data: 11'h012, pixel: 8'd18, ovf: 1'b0});
        exp_q.push_back('{data: 11'h409, pixel: 8'd9, ovf: 1'b0});
        for (int i = 0; i < TAPS - 1; i++) send_tap(sm(-1));
        s_data  = sm(-1);
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check_output("stall s_ready", 32'(s_ready), 32'd0);
            check_output("held m_valid", 32'(m_valid), 32'd1);
            check_output("held m_data", 32'(m_data), 32'h012);
            @(posedge aclk);
            #1;
        end
        m_ready = 1'b1;
        send_tap(sm(-1));
        s_valid = 1'b0;
        @(negedge aclk);
        check_output("B valid after release", 32'(m_valid), 32'd1);
        check_output("B data after release", 32'(m_data), 32'h409);
        idle(3);

        // Back-to-back: 18 taps in 18 cycles, results visible in cycles 10 and 19.
        for (int i = 0; i < TAPS; i++) stream[i] = sm(10);
        stream[9]  = sm(-10);
        stream[10] = sm(30);
        stream[11] = sm(-50);
        for (int i = 12; i < 17; i++) stream[i] = sm(0);
        stream[17] = sm(5);
        exp_q.push_back('{data: 11'h05A, pixel: 8'd90, ovf: 1'b0});
        exp_q.push_back('{data: 11'h419, pixel: 8'd25, ovf: 1'b0});
        accepts = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c <= 2 * TAPS) begin
                s_valid = 1'b1;
                s_data  = stream[c-1];
            end else begin
                s_valid = 1'b0;
            end
            @(negedge aclk);
            mv_seen[c] = m_valid;
            if (s_valid && s_ready) accepts++;
            @(posedge aclk);
            #1;
        end
        check_output("b2b accepts", 32'(accepts), 32'd18);
        check_output("b2b m_valid cycles", 32'(mv_seen), 32'h0004_0200);
        idle(3);

        // Reset mid-window discards the partial sum.
        for (int i = 0; i < 4; i++) send_tap(sm(7));
        s_valid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        check_output("midreset m_valid", 32'(m_valid), 32'd0);
        check_output("midreset m_data", 32'(m_data), 32'd0);
        check_output("midreset m_pixel", 32'(m_pixel), 32'd0);
        check_output("midreset m_ovf", 32'(m_ovf), 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int i = 0; i < TAPS; i++) win[i] = sm(1);
        apply_stimulus('{data: 11'h009, pixel: 8'd9, ovf: 1'b0});
        idle(5);

        check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
